aes_cmd_stream_master: RTL and testbench

- AXI-Stream transmitter that builds one complete AES engine command packet per accepted command: header word, 128-bit key, optional 128-bit IV, then payload.
- It is the sending end of the 32-bit stream that the AES engine's slave port receives, so the payload stream ends in tlast.
- Used in front of the engine by on-chip producers and by the loopback/self-test path.
- Key and IV are latched from a command interface. Payload words pass through from an upstream valid/ready source.

---
 rtl/aes_cmd_stream_master.sv | 198 +++++++++++++++++++
 tb/tb_aes_cmd_stream_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cmd_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : aes_cmd_stream_master
// Description : AXI-Stream transmitter that frames one AES engine command
//               packet per accepted command: header, key (4 words), optional
//               IV (4 words), then nblocks*4 payload words ending in tlast.
// Revision    : 1.0  initial release
// ============================================================================
module aes_cmd_stream_master #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int MAX_BLOCKS       = 512,
    parameter int CNT_W            = 12
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [31:0]                 cmd_header,
    input  logic [127:0]                cmd_key,
    input  logic [127:0]                cmd_iv,
    input  logic                        cmd_has_iv,
    input  logic [15:0]                 cmd_nblocks,
    input  logic                        din_valid,
    output logic                        din_ready,
    input  logic [AXIS_TDATA_WIDTH-1:0] din_data,
    output logic                        tvalid,
    input  logic                        tready,
    output logic [AXIS_TDATA_WIDTH-1:0] tdata,
    output logic [3:0]                  tstrb,
    output logic                        tlast,
    output logic                        busy,
    output logic                        cmd_err
);

    // HDR/KEY/IV: the word of that phase is being (or has just been) loaded;
    // idx names the next key/IV word to load. DATA: streaming payload.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        KEY  = 3'd2,
        IV   = 3'd3,
        DATA = 3'd4
    } state_t;

    localparam logic [15:0] MAX_NB = 16'(MAX_BLOCKS);

    state_t                      state, state_nxt;
    logic [1:0]                  idx, idx_nxt;
    logic [CNT_W-1:0]            cnt, cnt_nxt;
    logic                        tvalid_nxt, tlast_nxt;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_nxt;
    logic [127:0]                key_r, iv_r;
    logic                        has_iv_r;
    logic [CNT_W-3:0]            nblk_r;
    logic                        started;
    logic                        accept, cmd_bad, cmd_ok, load;
    logic [CNT_W-1:0]            total;

    // Selects one 32-bit word of a 128-bit value, most significant word first.
    function automatic logic [31:0] word_of(input logic [127:0] v, input logic [1:0] i);
        logic [31:0] w;
        case (i)
            2'd0:    w = v[127:96];
            2'd1:    w = v[95:64];
            2'd2:    w = v[63:32];
            default: w = v[31:0];
        endcase
        return w;
    endfunction

    assign cmd_ready = started && (state == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign cmd_bad   = (cmd_nblocks == 16'd0) || (cmd_nblocks > MAX_NB);
    assign cmd_ok    = accept && !cmd_bad;
    assign load      = !tvalid || tready;
    assign total     = {nblk_r, 2'b00};
    assign tstrb     = 4'hF;
    assign busy      = (state != IDLE);

    // Next-state and output-register load decisions.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        cnt_nxt    = cnt;
        tvalid_nxt = tvalid;
        tdata_nxt  = tdata;
        tlast_nxt  = tlast;
        din_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_ok) begin
                    state_nxt  = HDR;
                    tvalid_nxt = 1'b1;
                    tdata_nxt  = cmd_header;
                    tlast_nxt  = 1'b0;
                    cnt_nxt    = '0;
                    idx_nxt    = 2'd0;
                end
            end
            HDR: begin
                if (load) begin
                    tdata_nxt  = word_of(key_r, 2'd0);
                    tvalid_nxt = 1'b1;
                    idx_nxt    = 2'd1;
                    state_nxt  = KEY;
                end
            end
            KEY: begin
                if (load) begin
                    tdata_nxt  = word_of(key_r, idx);
                    tvalid_nxt = 1'b1;
                    idx_nxt    = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_nxt = has_iv_r ? IV : DATA;
                    end
                end
            end
            IV: begin
                if (load) begin
                    tdata_nxt  = word_of(iv_r, idx);
                    tvalid_nxt = 1'b1;
                    idx_nxt    = idx + 2'd1;
                    if (idx == 2'd3) begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == total) begin
                    // Final word is in the output register; finish on its handshake.
                    if (tready) begin
                        state_nxt  = IDLE;
                        tvalid_nxt = 1'b0;
                        tlast_nxt  = 1'b0;
                    end
                end else begin
                    din_ready = load;
                    if (load) begin
                        if (din_valid) begin
                            tdata_nxt  = din_data;
                            tvalid_nxt = 1'b1;
                            tlast_nxt  = (cnt == total - CNT_W'(1));
                            cnt_nxt    = cnt + CNT_W'(1);
                        end else begin
                            tvalid_nxt = 1'b0;
                            tlast_nxt  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_nxt  = IDLE;
                tvalid_nxt = 1'b0;
                tlast_nxt  = 1'b0;
            end
        endcase
    end

    // State, counters and the registered stream outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            idx     <= 2'd0;
            cnt     <= '0;
            tvalid  <= 1'b0;
            tdata   <= '0;
            tlast   <= 1'b0;
            cmd_err <= 1'b0;
            started <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx     <= idx_nxt;
            cnt     <= cnt_nxt;
            tvalid  <= tvalid_nxt;
            tdata   <= tdata_nxt;
            tlast   <= tlast_nxt;
            cmd_err <= accept && cmd_bad;
            started <= 1'b1;
        end
    end

    // Command fields captured on a valid accept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_r    <= '0;
            iv_r     <= '0;
            has_iv_r <= 1'b0;
            nblk_r   <= '0;
        end else if (cmd_ok) begin
            key_r    <= cmd_key;
            iv_r     <= cmd_iv;
            has_iv_r <= cmd_has_iv;
            nblk_r   <= cmd_nblocks[CNT_W-3:0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_cmd_stream_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_cmd_stream_master
// Description : Scoreboard bench for aes_cmd_stream_master. Commands push the
//               expected packet words; a monitor pops and compares on every
//               output handshake.
// Revision    : 1.0  initial release
// ============================================================================
module tb_aes_cmd_stream_master;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [31:0]  cmd_header = '0;
    logic [127:0] cmd_key = '0;
    logic [127:0] cmd_iv = '0;
    logic         cmd_has_iv = 1'b0;
    logic [15:0]  cmd_nblocks = '0;
    logic         din_valid;
    logic         din_ready;
    logic [31:0]  din_data;
    logic         tvalid;
    logic         tready;
    logic [31:0]  tdata;
    logic [3:0]   tstrb;
    logic         tlast;
    logic         busy;
    logic         cmd_err;

    aes_cmd_stream_master dut (
        .clk(clk), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_header(cmd_header),
        .cmd_key(cmd_key), .cmd_iv(cmd_iv), .cmd_has_iv(cmd_has_iv),
        .cmd_nblocks(cmd_nblocks),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .tvalid(tvalid), .tready(tready), .tdata(tdata), .tstrb(tstrb),
        .tlast(tlast), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] IV0  = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    localparam logic [127:0] KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] IV1  = 128'hF0F1F2F3F4F5F6F7F8F9FAFBFCFDFEFF;

    int          tests = 0;
    int          fails = 0;
    logic [32:0] exp_q[$];
    logic [31:0] din_q[$];
    int          tready_mode = 0;
    int          din_pct = 100;
    int          popped = 0;
    time         tlast_time = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issues one command; pushes its expected packet when it is a legal one.
    task automatic send_cmd(input logic [31:0] h, input logic [127:0] k,
                            input logic [127:0] iv, input logic hiv,
                            input logic [15:0] nb, input logic [31:0] pbase,
                            input logic b2b);
        logic ok;
        logic got;
        int   nw;
        ok = (nb != 16'd0) && (nb <= 16'd512);
        if (ok) begin
            exp_q.push_back({1'b0, h});
            for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, k[127-32*i -: 32]});
            if (hiv) for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, iv[127-32*i -: 32]});
            nw = 4 * int'(nb);
            for (int i = 0; i < nw; i++) begin
                exp_q.push_back({(i == nw - 1), pbase + 32'(i)});
                din_q.push_back(pbase + 32'(i));
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_header = h; cmd_key = k; cmd_iv = iv;
        cmd_has_iv = hiv; cmd_nblocks = nb;
        got = 1'b0;
        for (int i = 0; i < 5000 && !got; i++) begin
            @(negedge clk);
            if (cmd_ready) got = 1'b1;
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL cmd_accept_timeout: got no cmd_ready expected accept");
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (ok) begin
            chk("hdr_latency_valid", tvalid, 1);
            chk("hdr_latency_data", tdata, h);
            chk("busy_set", busy, 1);
            chk("no_err_on_ok", cmd_err, 0);
            if (b2b) chk("b2b_gap_time", $time - tlast_time, 16);
        end else begin
            chk("err_pulse", cmd_err, 1);
            chk("reject_no_valid", tvalid, 0);
            chk("reject_not_busy", busy, 0);
            @(posedge clk); #1;
            chk("err_one_cycle", cmd_err, 0);
            chk("reject_still_no_valid", tvalid, 0);
        end
    endtask

    // Waits (bounded) for the scoreboard to drain and the packet to end.
    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain_exp_empty", exp_q.size(), 0);
        chk("drain_busy_low", busy, 0);
        chk("drain_tvalid_low", tvalid, 0);
    endtask

    initial begin
        tready = 1'b0;
        din_valid = 1'b0;
        din_data = '0;
        fork
            // Sink/source driver: changes inputs 1 time unit after each rising edge.
            begin : drv
                logic hs;
                forever begin
                    @(negedge clk);
                    hs = din_valid && din_ready;
                    @(posedge clk); #1;
                    if (hs && din_q.size() > 0) void'(din_q.pop_front());
                    case (tready_mode)
                        0:       tready = 1'b1;
                        1:       tready = ~tready;
                        default: tready = 1'($urandom_range(0, 1));
                    endcase
                    if (din_q.size() > 0 && int'($urandom_range(0, 99)) < din_pct) begin
                        din_valid = 1'b1;
                        din_data  = din_q[0];
                    end else begin
                        din_valid = 1'b0;
                        din_data  = 32'hDEAD_BEEF;
                    end
                end
            end
            // Monitor: compares every handshaked word and checks stall stability.
            begin : mon
                logic        prev_stall;
                logic [31:0] prev_data;
                logic        prev_last;
                logic [32:0] e;
                prev_stall = 1'b0;
                prev_data  = '0;
                prev_last  = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!resetn) begin
                        prev_stall = 1'b0;
                    end else begin
                        if (prev_stall) begin
                            chk("stall_hold_valid", tvalid, 1);
                            chk("stall_hold_word", {tlast, tdata}, {prev_last, prev_data});
                        end
                        if (tvalid && tready) begin
                            if (exp_q.size() == 0) begin
                                tests++; fails++;
                                $display("FAIL unexpected_word: got %0h expected none", {tlast, tdata});
                            end else begin
                                e = exp_q.pop_front();
                                chk("stream_word", {tlast, tdata}, e);
                            end
                            popped++;
                            if (tlast) tlast_time = $time;
                        end
                        prev_stall = tvalid && !tready;
                        prev_data  = tdata;
                        prev_last  = tlast;
                    end
                end
            end
        join_none

        // Reset state.
        #12;
        chk("rst_outputs", {tvalid, tlast, busy, cmd_err, din_ready, cmd_ready}, 0);
        chk("rst_tdata", tdata, 0);
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;
        chk("idle_cmd_ready", cmd_ready, 1);
        chk("tstrb_const", tstrb, 4'hF);

        // ECB, one block, free-flowing sink.
        tready_mode = 0; din_pct = 100; popped = 0;
        send_cmd(32'h0000_0001, KEY0, IV0, 1'b0, 16'd1, 32'h1000_0000, 1'b0);
        wait_done(200);
        chk("ecb_word_count", popped, 9);

        // CBC, two blocks.
        popped = 0;
        send_cmd(32'h0000_0012, KEY0, IV0, 1'b1, 16'd2, 32'h2000_0000, 1'b0);
        wait_done(200);
        chk("cbc_word_count", popped, 17);

        // Backpressure: toggling tready, sparse payload.
        tready_mode = 1; din_pct = 60; popped = 0;
        send_cmd(32'h0000_0022, KEY1, IV1, 1'b1, 16'd3, 32'h3000_0000, 1'b0);
        wait_done(500);
        chk("bp_word_count", popped, 21);

        // Random tready and payload gaps, ECB.
        tready_mode = 2; din_pct = 50; popped = 0;
        send_cmd(32'h0000_0031, KEY1, IV1, 1'b0, 16'd4, 32'h4000_0000, 1'b0);
        wait_done(500);
        chk("rand_word_count", popped, 21);

        // Rejections, then the largest legal packet.
        tready_mode = 0; din_pct = 100; popped = 0;
        send_cmd(32'h0000_00E0, KEY0, IV0, 1'b0, 16'd0, 32'h0, 1'b0);
        send_cmd(32'h0000_00E1, KEY0, IV0, 1'b0, 16'd513, 32'h0, 1'b0);
        chk("reject_no_words", popped, 0);
        send_cmd(32'h0000_0042, KEY1, IV0, 1'b1, 16'd512, 32'h5000_0000, 1'b0);
        wait_done(5000);
        chk("max_word_count", popped, 2057);

        // Back-to-back commands: the second waits for the first packet's tlast.
        tready_mode = 0; din_pct = 100;
        send_cmd(32'h0000_0051, KEY0, IV0, 1'b0, 16'd2, 32'h6000_0000, 1'b0);
        send_cmd(32'h0000_0052, KEY1, IV1, 1'b1, 16'd1, 32'h7000_0000, 1'b1);
        wait_done(300);

        // Asynchronous reset during the payload of a 9-word packet.
        popped = 0;
        send_cmd(32'h0000_0061, KEY0, IV0, 1'b0, 16'd1, 32'h8000_0000, 1'b0);
        for (int i = 0; i < 50 && popped < 6; i++) begin
            @(posedge clk); #2;
        end
        chk("pre_reset_progress", popped, 6);
        resetn = 1'b0;
        #1;
        chk("mid_reset_tvalid", tvalid, 0);
        chk("mid_reset_busy", busy, 0);
        chk("mid_reset_ready", {cmd_ready, din_ready}, 0);
        exp_q.delete();
        din_q.delete();
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        popped = 0;
        send_cmd(32'h0000_0071, KEY1, IV1, 1'b1, 16'd1, 32'h9000_0000, 1'b0);
        wait_done(200);
        chk("post_reset_word_count", popped, 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
